axi_arp_reply_tx: RTL and testbench

- Downstream consumer of the ARP receive parser's decoded fields (arp_valid/arp_ready bundle).
- Filters for ARP requests addressed to the local IP and serialises a complete 42-byte Ethernet+ARP reply frame onto a byte-wide AXI-Stream master, which feeds the MAC TX arbiter.
- Non-matching or non-request ARP messages are consumed and counted as drops.

---
 rtl/axi_udp_pkg.sv | 17 +
 rtl/axi_arp_reply_tx.sv | 151 +++++++++++++++
 tb/tb_axi_arp_reply_tx.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_udp_pkg.sv
// Shared Ethernet/ARP constants for the UDP/ARP offload blocks.
package axi_udp_pkg;

    localparam logic [15:0] ARP_HW_TYPE    = 16'h0001;
    localparam logic [15:0] ARP_PROTO_TYPE = 16'h0800;
    localparam logic [7:0]  ARP_HW_SIZE    = 8'h06;
    localparam logic [7:0]  ARP_PROTO_SIZE = 8'h04;

    localparam logic [15:0] ARP_OP_REQUEST = 16'h0001;
    localparam logic [15:0] ARP_OP_REPLY   = 16'h0002;

    localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;
    localparam int unsigned ARP_FRAME_LEN  = 42;

    localparam logic [5:0]  ARP_LAST_INDEX = 6'(ARP_FRAME_LEN - 1);

endpackage

// File: rtl/axi_arp_reply_tx.sv
// Answers ARP requests for the local IP by streaming a 42-byte Ethernet+ARP
// reply on a byte-wide AXI-Stream master; everything else is counted as a drop.
module axi_arp_reply_tx
    import axi_udp_pkg::*;
#(
    parameter int          DEBUG   = 1,
    parameter logic [23:0] MAC_MSB = 24'h010203,
    parameter logic [23:0] MAC_LSB = 24'h040506,
    parameter logic [15:0] IP_MSB  = 16'hc0a8,
    parameter logic [15:0] IP_LSB  = 16'h0602
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        arp_valid,
    output logic        arp_ready,
    input  logic [15:0] arp_opcode,
    input  logic [47:0] arp_src_mac,
    input  logic [31:0] arp_src_ip,
    input  logic [47:0] arp_dst_mac,
    input  logic [31:0] arp_dst_ip,
    output logic        m_axis_tvalid,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tlast,
    input  logic        m_axis_tready,
    output logic [15:0] tx_count,
    output logic [15:0] drop_count
);

    typedef logic [0:0] state_t;
    localparam state_t S_IDLE = 1'b0;
    localparam state_t S_SEND = 1'b1;

    typedef struct packed {
        state_t      state;
        logic [5:0]  index;
        logic [47:0] mac;
        logic [31:0] ip;
        logic [15:0] tx_count;
        logic [15:0] drop_count;
    } reg_t;

    localparam logic [47:0] LOCAL_MAC = {MAC_MSB, MAC_LSB};
    localparam logic [31:0] LOCAL_IP  = {IP_MSB, IP_LSB};

    if (DEBUG > 1) begin : g_debug_range
        $error("DEBUG must be 0 or 1");
    end

    reg_t       r_q;
    reg_t       w_next;
    logic [7:0] w_byte;
    logic       w_unused;

    // The target MAC in a request is normally zero/broadcast and carries no information.
    assign w_unused = ^arp_dst_mac;

    always_comb begin
        w_byte = 8'h00;
        case (r_q.index)
            6'd0:  w_byte = r_q.mac[47:40];
            6'd1:  w_byte = r_q.mac[39:32];
            6'd2:  w_byte = r_q.mac[31:24];
            6'd3:  w_byte = r_q.mac[23:16];
            6'd4:  w_byte = r_q.mac[15:8];
            6'd5:  w_byte = r_q.mac[7:0];
            6'd6:  w_byte = LOCAL_MAC[47:40];
            6'd7:  w_byte = LOCAL_MAC[39:32];
            6'd8:  w_byte = LOCAL_MAC[31:24];
            6'd9:  w_byte = LOCAL_MAC[23:16];
            6'd10: w_byte = LOCAL_MAC[15:8];
            6'd11: w_byte = LOCAL_MAC[7:0];
            6'd12: w_byte = ETHERTYPE_ARP[15:8];
            6'd13: w_byte = ETHERTYPE_ARP[7:0];
            6'd14: w_byte = ARP_HW_TYPE[15:8];
            6'd15: w_byte = ARP_HW_TYPE[7:0];
            6'd16: w_byte = ARP_PROTO_TYPE[15:8];
            6'd17: w_byte = ARP_PROTO_TYPE[7:0];
            6'd18: w_byte = ARP_HW_SIZE;
            6'd19: w_byte = ARP_PROTO_SIZE;
            6'd20: w_byte = ARP_OP_REPLY[15:8];
            6'd21: w_byte = ARP_OP_REPLY[7:0];
            6'd22: w_byte = LOCAL_MAC[47:40];
            6'd23: w_byte = LOCAL_MAC[39:32];
            6'd24: w_byte = LOCAL_MAC[31:24];
            6'd25: w_byte = LOCAL_MAC[23:16];
            6'd26: w_byte = LOCAL_MAC[15:8];
            6'd27: w_byte = LOCAL_MAC[7:0];
            6'd28: w_byte = LOCAL_IP[31:24];
            6'd29: w_byte = LOCAL_IP[23:16];
            6'd30: w_byte = LOCAL_IP[15:8];
            6'd31: w_byte = LOCAL_IP[7:0];
            6'd32: w_byte = r_q.mac[47:40];
            6'd33: w_byte = r_q.mac[39:32];
            6'd34: w_byte = r_q.mac[31:24];
            6'd35: w_byte = r_q.mac[23:16];
            6'd36: w_byte = r_q.mac[15:8];
            6'd37: w_byte = r_q.mac[7:0];
            6'd38: w_byte = r_q.ip[31:24];
            6'd39: w_byte = r_q.ip[23:16];
            6'd40: w_byte = r_q.ip[15:8];
            6'd41: w_byte = r_q.ip[7:0];
            default: w_byte = 8'h00;
        endcase
    end

    always_comb begin
        w_next = r_q;
        case (r_q.state)
            S_IDLE: begin
                if (arp_valid) begin
                    if (arp_opcode == ARP_OP_REQUEST && arp_dst_ip == LOCAL_IP) begin
                        w_next.state = S_SEND;
                        w_next.index = '0;
                        w_next.mac   = arp_src_mac;
                        w_next.ip    = arp_src_ip;
                    end else begin
                        w_next.drop_count = r_q.drop_count + 16'd1;
                    end
                end
            end
            S_SEND: begin
                if (m_axis_tready) begin
                    if (r_q.index == ARP_LAST_INDEX) begin
                        w_next.state    = S_IDLE;
                        w_next.index    = '0;
                        w_next.tx_count = r_q.tx_count + 16'd1;
                    end else begin
                        w_next.index = r_q.index + 6'd1;
                    end
                end
            end
            default: w_next.state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else begin
            r_q <= w_next;
        end
    end

    assign arp_ready     = (r_q.state == S_IDLE);
    assign m_axis_tvalid = (r_q.state == S_SEND);
    assign m_axis_tlast  = (r_q.state == S_SEND) && (r_q.index == ARP_LAST_INDEX);
    assign m_axis_tdata  = (r_q.state == S_SEND) ? w_byte : 8'h00;
    assign tx_count      = r_q.tx_count;
    assign drop_count    = r_q.drop_count;

endmodule

// File: tb/tb_axi_arp_reply_tx.sv
// Directed bench for axi_arp_reply_tx: reply framing, filtering, stalls,
// back-to-back requests, mid-frame reset and drop counter wrap.
module tb_axi_arp_reply_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        arp_valid;
    logic        arp_ready;
    logic [15:0] arp_opcode;
    logic [47:0] arp_src_mac;
    logic [31:0] arp_src_ip;
    logic [47:0] arp_dst_mac;
    logic [31:0] arp_dst_ip;
    logic        m_axis_tvalid;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tlast;
    logic        m_axis_tready;
    logic [15:0] tx_count;
    logic [15:0] drop_count;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [7:0]  exp_frame [42];

    axi_arp_reply_tx #(
        .DEBUG   (1),
        .MAC_MSB (24'h010203),
        .MAC_LSB (24'h040506),
        .IP_MSB  (16'hc0a8),
        .IP_LSB  (16'h0602)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .arp_valid     (arp_valid),
        .arp_ready     (arp_ready),
        .arp_opcode    (arp_opcode),
        .arp_src_mac   (arp_src_mac),
        .arp_src_ip    (arp_src_ip),
        .arp_dst_mac   (arp_dst_mac),
        .arp_dst_ip    (arp_dst_ip),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .tx_count      (tx_count),
        .drop_count    (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hand-laid reply for local MAC 01:02:03:04:05:06 / IP c0.a8.06.02.
    task automatic build_exp(input logic [47:0] mac, input logic [31:0] ip);
        logic [7:0] hdr [22];
        hdr = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                8'h08, 8'h06, 8'h00, 8'h01, 8'h08, 8'h00,
                8'h06, 8'h04, 8'h00, 8'h02};
        for (int i = 0; i < 22; i++) exp_frame[i] = hdr[i];
        for (int i = 0; i < 6; i++) begin
            exp_frame[i]      = mac[47 - 8*i -: 8];
            exp_frame[22 + i] = 8'(i + 1);
            exp_frame[32 + i] = mac[47 - 8*i -: 8];
        end
        exp_frame[28] = 8'hc0; exp_frame[29] = 8'ha8;
        exp_frame[30] = 8'h06; exp_frame[31] = 8'h02;
        for (int i = 0; i < 4; i++) exp_frame[38 + i] = ip[31 - 8*i -: 8];
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Pulses one message; inputs are scrambled afterwards to prove single sampling.
    task automatic send_msg(input logic [15:0] op, input logic [31:0] dip,
                            input logic [47:0] mac, input logic [31:0] ip);
        arp_valid   = 1'b1;
        arp_opcode  = op;
        arp_dst_ip  = dip;
        arp_src_mac = mac;
        arp_src_ip  = ip;
        arp_dst_mac = 48'h0;
        @(posedge clk); #1;
        arp_valid   = 1'b0;
        arp_src_mac = 48'hdeadbeefcafe;
        arp_src_ip  = 32'h12345678;
    endtask

    // Collects one frame; random_ready toggles tready and checks stall stability.
    task automatic run_frame(input string tag, input bit random_ready);
        int unsigned got = 0;
        int unsigned cyc = 0;
        bit          prev_stall = 1'b0;
        logic [7:0]  prev_data = 8'h00;
        logic        prev_last = 1'b0;
        while (got < 42 && cyc < 400) begin
            m_axis_tready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (prev_stall) begin
                check({tag, " stall_tdata"}, 64'(m_axis_tdata), 64'(prev_data));
                check({tag, " stall_tlast"}, 64'(m_axis_tlast), 64'(prev_last));
            end
            if (m_axis_tvalid) check({tag, " ready_low"}, 64'(arp_ready), 64'd0);
            if (m_axis_tvalid && m_axis_tready) begin
                check($sformatf("%s byte%0d", tag, got), 64'(m_axis_tdata), 64'(exp_frame[got]));
                check($sformatf("%s last%0d", tag, got), 64'(m_axis_tlast), 64'(got == 41));
                got++;
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
            @(posedge clk); #1;
            cyc++;
        end
        if (got < 42) check({tag, " timeout"}, 64'(got), 64'd42);
        m_axis_tready = 1'b1;
    endtask

    initial begin
        reset         = 1'b1;
        arp_valid     = 1'b0;
        arp_opcode    = 16'h0;
        arp_src_mac   = 48'h0;
        arp_src_ip    = 32'h0;
        arp_dst_mac   = 48'h0;
        arp_dst_ip    = 32'h0;
        m_axis_tready = 1'b1;
        @(posedge clk); #1;
        do_reset();

        @(negedge clk);
        check("rst arp_ready", 64'(arp_ready), 64'd1);
        check("rst tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst tlast", 64'(m_axis_tlast), 64'd0);
        check("rst tdata", 64'(m_axis_tdata), 64'd0);
        check("rst tx_count", 64'(tx_count), 64'd0);
        check("rst drop_count", 64'(drop_count), 64'd0);
        @(posedge clk); #1;

        // Basic reply with tready held high.
        build_exp(48'ha0b0c0d0e0f0, 32'hc0a80601);
        check("exp sanity b12", 64'(exp_frame[12]), 64'h08);
        send_msg(16'h0001, 32'hc0a80602, 48'ha0b0c0d0e0f0, 32'hc0a80601);
        @(negedge clk);
        check("t1 first tvalid", 64'(m_axis_tvalid), 64'd1);
        check("t1 first tdata", 64'(m_axis_tdata), 64'ha0);
        @(posedge clk);
        #1;
        // That edge consumed byte 0 with tready high; re-run from a fresh request instead.
        do_reset();
        send_msg(16'h0001, 32'hc0a80602, 48'ha0b0c0d0e0f0, 32'hc0a80601);
        run_frame("t1", 1'b0);
        @(negedge clk);
        check("t1 tx_count", 64'(tx_count), 64'd1);
        check("t1 ready back", 64'(arp_ready), 64'd1);
        check("t1 idle tvalid", 64'(m_axis_tvalid), 64'd0);
        @(posedge clk); #1;

        // Wrong target IP, then a reply opcode to the local IP: both dropped.
        send_msg(16'h0001, 32'hc0a80603, 48'ha0b0c0d0e0f0, 32'hc0a80601);
        send_msg(16'h0002, 32'hc0a80602, 48'ha0b0c0d0e0f0, 32'hc0a80601);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t2 tvalid", 64'(m_axis_tvalid), 64'd0);
            check("t2 arp_ready", 64'(arp_ready), 64'd1);
            @(posedge clk); #1;
        end
        check("t2 drop_count", 64'(drop_count), 64'd2);
        check("t2 tx_count", 64'(tx_count), 64'd1);

        // Backpressure with random tready.
        send_msg(16'h0001, 32'hc0a80602, 48'ha0b0c0d0e0f0, 32'hc0a80601);
        run_frame("t3", 1'b1);
        check("t3 tx_count", 64'(tx_count), 64'd2);

        // Back-to-back with arp_valid held; fields change right after the first accept.
        arp_valid   = 1'b1;
        arp_opcode  = 16'h0001;
        arp_dst_ip  = 32'hc0a80602;
        arp_src_mac = 48'h112233445566;
        arp_src_ip  = 32'h0a000001;
        @(posedge clk); #1;
        arp_src_mac = 48'h778899aabbcc;
        arp_src_ip  = 32'h0a000002;
        build_exp(48'h112233445566, 32'h0a000001);
        run_frame("t4a", 1'b0);
        @(negedge clk);
        check("t4 ready after tlast", 64'(arp_ready), 64'd1);
        check("t4 gap tvalid", 64'(m_axis_tvalid), 64'd0);
        @(posedge clk); #1;
        arp_valid = 1'b0;
        build_exp(48'h778899aabbcc, 32'h0a000002);
        run_frame("t4b", 1'b0);
        check("t4 tx_count", 64'(tx_count), 64'd4);

        // Reset while byte 20 is on the bus.
        build_exp(48'ha0b0c0d0e0f0, 32'hc0a80601);
        send_msg(16'h0001, 32'hc0a80602, 48'ha0b0c0d0e0f0, 32'hc0a80601);
        repeat (20) @(posedge clk);
        #1;
        @(negedge clk);
        check("t5 idx20 tdata", 64'(m_axis_tdata), 64'(exp_frame[20]));
        check("t5 idx20 tvalid", 64'(m_axis_tvalid), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("t5 rst tvalid", 64'(m_axis_tvalid), 64'd0);
        check("t5 rst tlast", 64'(m_axis_tlast), 64'd0);
        check("t5 rst arp_ready", 64'(arp_ready), 64'd1);
        check("t5 rst tx_count", 64'(tx_count), 64'd0);
        check("t5 rst drop_count", 64'(drop_count), 64'd0);
        @(posedge clk); #1;
        send_msg(16'h0001, 32'hc0a80602, 48'ha0b0c0d0e0f0, 32'hc0a80601);
        run_frame("t5", 1'b0);
        check("t5 tx_count", 64'(tx_count), 64'd1);

        // Drop counter wrap: hold a non-request message valid for 65535 cycles.
        arp_valid  = 1'b1;
        arp_opcode = 16'h0002;
        repeat (65535) @(posedge clk);
        #1;
        check("t6 drop ffff", 64'(drop_count), 64'hffff);
        @(posedge clk); #1;
        check("t6 drop wrap", 64'(drop_count), 64'd0);
        @(posedge clk); #1;
        arp_valid = 1'b0;
        check("t6 drop one", 64'(drop_count), 64'd1);
        check("t6 tx unchanged", 64'(tx_count), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
